// File: rtl/gameman_pkg.sv
// gameman_pkg: shared HDMA state encoding and register offsets.
package gameman_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_HBL, RD, WR} hdma_state_t;
    localparam logic [2:0] HDMA1_OFS = 3'd0;
    localparam logic [2:0] HDMA2_OFS = 3'd1;
    localparam logic [2:0] HDMA3_OFS = 3'd2;
    localparam logic [2:0] HDMA4_OFS = 3'd3;
    localparam logic [2:0] HDMA5_OFS = 3'd4;
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;
endpackage

// File: rtl/mem_if.sv
// mem_if: simple byte-wide memory bus shared by the CPU register port and the DMA master.
interface mem_if;
    logic [15:0] addr_select;
    logic        write_enable;
    logic [7:0]  write_value;
    logic [7:0]  read_out;
    modport master(output addr_select, write_enable, write_value, input read_out);
    modport slave(input addr_select, write_enable, write_value, output read_out);
endinterface

// File: rtl/mmio_hdma_regs_m.sv
// mmio_hdma_regs_m: HDMA register decode, write-strobe edge detect and registered read port.
module mmio_hdma_regs_m
    import gameman_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF51
) (
    input  logic       clk,
    input  logic       rst,
    mem_if.slave       req,
    input  logic [7:0] hdma5_val,
    output logic       wr_stb,
    output logic [2:0] wr_sel,
    output logic [7:0] wr_val
);
    logic        we_q;
    logic [15:0] ofs;
    logic        hit;
    always_comb begin
        ofs    = req.addr_select - BASE_ADDR;
        hit    = ofs < 16'd5;
        wr_sel = ofs[2:0];
        wr_val = req.write_value;
        wr_stb = hit && req.write_enable && !we_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            req.read_out <= 8'hFF;
        end else begin
            we_q         <= req.write_enable;
            req.read_out <= (hit && wr_sel == HDMA5_OFS) ? hdma5_val : 8'hFF;
        end
    end
endmodule

// File: rtl/mmio_hdma_m.sv
// mmio_hdma_m: CGB-style HDMA engine copying blocks into the VRAM window,
// either back-to-back (GP) or one block per HBlank.
module mmio_hdma_m
    import gameman_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF51,
    parameter int          BLOCK_BYTES  = 16,
    parameter int          LEN_BITS     = 7,
    parameter int          READ_CYCLES  = 2,
    parameter int          WRITE_CYCLES = 1,
    parameter logic [15:0] DST_BASE     = 16'h8000
) (
    input  logic clk,
    input  logic rst,
    mem_if.slave  req,
    mem_if.master dma_req,
    input  logic hblank_start,
    output logic busy
);
    localparam logic [7:0] LOW_MASK = 8'(BLOCK_BYTES - 1);
    localparam logic [7:0] RD_LAST  = 8'(READ_CYCLES - 1);
    localparam logic [7:0] WR_LAST  = 8'(WRITE_CYCLES - 1);
    localparam logic [7:0] BLK_LAST = 8'(BLOCK_BYTES - 1);

    hdma_state_t         state, state_n;
    logic [15:0]         src;
    logic [12:0]         dst;
    logic [LEN_BITS-1:0] len;
    logic [7:0]          cyc, bcnt, data;
    logic                hbl_mode, cancel_pend, cancelled;
    logic                wr_stb;
    logic [2:0]          wr_sel;
    logic [7:0]          wr_val, hdma5_val;
    logic                h5_wr, h5_cancel, rd_done, byte_done, blk_end, last_blk, stop_hbl;

    mmio_hdma_regs_m #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .clk(clk),
        .rst(rst),
        .req(req),
        .hdma5_val(hdma5_val),
        .wr_stb(wr_stb),
        .wr_sel(wr_sel),
        .wr_val(wr_val)
    );

    always_comb begin
        h5_wr     = wr_stb && wr_sel == HDMA5_OFS;
        h5_cancel = h5_wr && !wr_val[7] && hbl_mode && state != IDLE;
        rd_done   = state == RD && cyc == RD_LAST;
        byte_done = state == WR && cyc == WR_LAST;
        blk_end   = byte_done && bcnt == BLK_LAST;
        last_blk  = len == '0;
        stop_hbl  = cancel_pend || h5_cancel;
        state_n   = state;
        case (state)
            IDLE:     if (h5_wr) state_n = wr_val[7] ? WAIT_HBL : RD;
            WAIT_HBL: state_n = h5_cancel ? IDLE : hblank_start ? RD : WAIT_HBL;
            RD:       if (rd_done) state_n = WR;
            WR:       if (byte_done) state_n = !blk_end ? RD : last_blk ? IDLE :
                                               !hbl_mode ? RD : stop_hbl ? IDLE : WAIT_HBL;
            default:  state_n = IDLE;
        endcase
        busy                 = state == RD || state == WR;
        dma_req.addr_select  = state == RD ? src : state == WR ? DST_BASE + {3'b000, dst} : BUS_IDLE;
        dma_req.write_enable = state == WR;
        dma_req.write_value  = data;
        hdma5_val            = state != IDLE ? {1'b0, 7'(len)} : cancelled ? {1'b1, 7'(len)} : 8'hFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Address registers only accept writes while idle; HDMA5 in idle arms a new transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src         <= '0;
            dst         <= '0;
            len         <= '0;
            cyc         <= '0;
            bcnt        <= '0;
            data        <= '0;
            hbl_mode    <= 1'b0;
            cancel_pend <= 1'b0;
            cancelled   <= 1'b0;
        end else begin
            cyc <= state_n == state ? cyc + 8'd1 : 8'd0;
            if (state == IDLE && wr_stb) begin
                if (wr_sel == HDMA1_OFS) src[15:8] <= wr_val;
                if (wr_sel == HDMA2_OFS) src[7:0]  <= wr_val & ~LOW_MASK;
                if (wr_sel == HDMA3_OFS) dst[12:8] <= wr_val[4:0];
                if (wr_sel == HDMA4_OFS) dst[7:0]  <= wr_val & ~LOW_MASK;
                if (wr_sel == HDMA5_OFS) begin
                    len         <= wr_val[LEN_BITS-1:0];
                    hbl_mode    <= wr_val[7];
                    cancel_pend <= 1'b0;
                    cancelled   <= 1'b0;
                    bcnt        <= '0;
                end
            end
            if (rd_done) data <= dma_req.read_out;
            if (byte_done) begin
                src  <= src + 16'd1;
                dst  <= dst + 13'd1;
                bcnt <= blk_end ? 8'd0 : bcnt + 8'd1;
            end
            if (h5_cancel && state != WAIT_HBL) cancel_pend <= 1'b1;
            if (blk_end) len <= len - 1'b1;
            if ((state == WAIT_HBL && h5_cancel) || (blk_end && !last_blk && hbl_mode && stop_hbl))
                cancelled <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mmio_hdma_m.sv
// tb_mmio_hdma_m: random-data bench; expected writes come from src/dst/length arithmetic.
module tb_mmio_hdma_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hbl = 1'b0;
    logic busy;
    mem_if cpu();
    mem_if dma();

    mmio_hdma_m dut (
        .clk(clk),
        .rst(rst),
        .req(cpu.slave),
        .dma_req(dma.master),
        .hblank_start(hbl),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    logic [23:0] obs [$];
    int          busy_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          seen = 0;
    logic [15:0] m_src;
    logic [12:0] m_dst;

    assign dma.read_out = mem[dma.addr_select];
    always @(posedge clk) if (dma.write_enable) mem[dma.addr_select] <= dma.write_value;
    always @(negedge clk) begin
        if (dma.write_enable) obs.push_back({dma.addr_select, dma.write_value});
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] v, input int hold = 1);
        cpu.addr_select  = a;
        cpu.write_value  = v;
        cpu.write_enable = 1'b1;
        repeat (hold) tick();
        cpu.write_enable = 1'b0;
        cpu.addr_select  = 16'h0000;
        tick();
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [7:0] v);
        cpu.addr_select = a;
        tick();
        v = cpu.read_out;
        cpu.addr_select = 16'h0000;
    endtask

    task automatic pulse;
        hbl = 1'b1;
        tick();
        hbl = 1'b0;
    endtask

    task automatic set_src(input logic [15:0] s);
        wr_reg(16'hFF51, s[15:8]);
        wr_reg(16'hFF52, s[7:0]);
        m_src = s & 16'hFFF0;
        seen  = obs.size();
    endtask

    task automatic set_dst(input logic [15:0] d);
        wr_reg(16'hFF53, d[15:8]);
        wr_reg(16'hFF54, d[7:0]);
        m_dst = d[12:0] & 13'h1FF0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, busy, 0);
    endtask

    // Each byte k of a transfer goes from src+k to the VRAM window at (dst+k) mod 8 KiB.
    task automatic check_writes(input string tag, input int n);
        check({tag, "_cnt"}, obs.size() - seen, n);
        for (int i = 0; i < n && seen < obs.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {8'h00, obs[seen]},
                  {8'h00, 16'h8000 + {3'b000, m_dst}, mem[m_src]});
            seen++;
            m_src++;
            m_dst++;
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int b = busy_cnt;
        int s = obs.size();
        repeat (n) tick();
        check({tag, "_nowr"}, obs.size() - s, 0);
        check({tag, "_nobusy"}, busy_cnt - b, 0);
        seen = obs.size();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] hexp [3];
        int b;
        int s;
        hexp = '{8'h01, 8'h00, 8'hFF};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        cpu.addr_select  = 16'h0000;
        cpu.write_enable = 1'b0;
        cpu.write_value  = 8'h00;
        repeat (3) tick();
        check("rst_addr", dma.addr_select, 16'hFFFF);
        check("rst_we", dma.write_enable, 0);
        check("rst_wv", dma.write_value, 0);
        check("rst_rd", cpu.read_out, 8'hFF);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        set_src(16'hC000);
        set_dst(16'h0000);
        b = busy_cnt;
        wr_reg(16'hFF55, 8'h01);
        wait_done("gp");
        check_writes("gp", 32);
        check("gp_busy", busy_cnt - b, 96);
        rd_reg(16'hFF55, v);
        check("gp_h5", v, 8'hFF);

        set_src({3'b110, 13'($urandom)});
        set_dst(16'h0200);
        wr_reg(16'hFF55, 8'h82);
        rd_reg(16'hFF55, v);
        check("hbl_h5_wait", v, 8'h02);
        quiet("hbl_pre", 10);
        for (int k = 0; k < 3; k++) begin
            b = busy_cnt;
            pulse();
            wait_done($sformatf("hbl%0d", k));
            check_writes($sformatf("hbl%0d", k), 16);
            check($sformatf("hbl%0d_busy", k), busy_cnt - b, 48);
            rd_reg(16'hFF55, v);
            check($sformatf("hbl%0d_h5", k), v, hexp[k]);
            quiet($sformatf("hbl%0d_gap", k), 10);
        end
        pulse();
        quiet("hbl_extra", 60);

        set_src({3'b110, 13'($urandom)});
        set_dst(16'h0400);
        cpu.addr_select  = 16'hFF55;
        cpu.write_value  = 8'h83;
        cpu.write_enable = 1'b1;
        hbl = 1'b1;
        tick();
        cpu.write_enable = 1'b0;
        cpu.addr_select  = 16'h0000;
        hbl = 1'b0;
        tick();
        quiet("coinc", 8);
        pulse();
        wait_done("can1");
        check_writes("can1", 16);
        rd_reg(16'hFF55, v);
        check("can1_h5", v, 8'h02);
        wr_reg(16'hFF55, 8'h00);
        rd_reg(16'hFF55, v);
        check("can_h5", v, 8'h82);
        pulse();
        quiet("can_after", 60);

        set_src({3'b110, 13'($urandom)});
        set_dst(16'h0600);
        wr_reg(16'hFF55, 8'h81);
        pulse();
        repeat (5) tick();
        wr_reg(16'hFF55, 8'h00);
        wait_done("mid");
        check_writes("mid", 16);
        rd_reg(16'hFF55, v);
        check("mid_h5", v, 8'h80);
        pulse();
        quiet("mid_after", 60);

        set_src(16'hC800);
        set_dst(16'h1FF0);
        wr_reg(16'hFF55, 8'h01);
        wait_done("wrap");
        check_writes("wrap", 32);

        set_src(16'hC100);
        set_dst(16'h0100);
        s = obs.size();
        wr_reg(16'hFF55, 8'h00);
        repeat (12) tick();
        check("rst_pre", obs.size() - s, 4);
        rst = 1'b1;
        #1;
        check("rst_mid_addr", dma.addr_select, 16'hFFFF);
        check("rst_mid_we", dma.write_enable, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        quiet("rst_post", 60);
        rd_reg(16'hFF55, v);
        check("rst_h5", v, 8'hFF);

        set_src(16'hC200);
        set_dst(16'h0300);
        b = busy_cnt;
        wr_reg(16'hFF55, 8'h00, 4);
        repeat (5) tick();
        pulse();
        wait_done("hold");
        check_writes("hold", 16);
        check("hold_busy", busy_cnt - b, 48);

        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(0, 2);
            set_src({3'b110, 13'($urandom)});
            set_dst(16'($urandom));
            b = busy_cnt;
            wr_reg(16'hFF55, 8'(n));
            wait_done($sformatf("rnd%0d", r));
            check_writes($sformatf("rnd%0d", r), (n + 1) * 16);
            check($sformatf("rnd%0d_busy", r), busy_cnt - b, (n + 1) * 48);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
